updown_counter: RTL

- Parametrised successor to the 9-bit free-running counter: an up/down counter with variable step, synchronous load/clear, a programmable modulus, and a wrap or saturate mode.
- Sits in the bf-cpu datapath as the common engine for the program counter, the data pointer (`>`/`<`) and the loop-depth tracker (`[`/`]`).
- Also emits boundary flags and single-cycle overflow/underflow/error pulses for the control FSM.

---
 rtl/counter_pkg.sv | 47 ++++
 rtl/updown_counter.sv | 101 ++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and next-state arithmetic for the up/down counter
package counter_pkg;

  typedef enum logic {MODE_WRAP, MODE_SAT} cnt_mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} cnt_dir_e;

  localparam int unsigned CNT_W_MAX = 32;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] value;
    logic                 wrap;
  } cnt_next_t;

  // One extra bit of headroom so the crossing is detected before any truncation.
  function automatic cnt_next_t next_count(
    input logic [CNT_W_MAX-1:0] cur,
    input logic [CNT_W_MAX-1:0] step,
    input cnt_dir_e             dir,
    input cnt_mode_e            mode,
    input logic [CNT_W_MAX-1:0] max
  );
    logic [CNT_W_MAX:0] sum;
    cnt_next_t          r;
    sum     = '0;
    r.value = cur;
    r.wrap  = 1'b0;
    if (dir == DIR_UP) begin
      sum = {1'b0, cur} + {1'b0, step};
      if (sum > {1'b0, max}) begin
        r.wrap  = 1'b1;
        r.value = (mode == MODE_WRAP) ? CNT_W_MAX'(sum - {1'b0, max} - 1'b1) : max;
      end else begin
        r.value = sum[CNT_W_MAX-1:0];
      end
    end else begin
      if (step > cur) begin
        r.wrap  = 1'b1;
        sum     = {1'b0, cur} + {1'b0, max} + 1'b1 - {1'b0, step};
        r.value = (mode == MODE_WRAP) ? sum[CNT_W_MAX-1:0] : '0;
      end else begin
        r.value = cur - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - up/down counter with step, load/clear, modulus and wrap/saturate mode
module updown_counter
  import counter_pkg::*;
#(
  parameter int        WIDTH       = 9,
  parameter int        MAX_VALUE   = 2**WIDTH-1,
  parameter int        STEP_W      = 4,
  parameter int        RESET_VALUE = 0,
  parameter cnt_mode_e MODE        = MODE_WRAP
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              at_zero,
  output logic              at_max,
  output logic              ovf,
  output logic              udf,
  output logic              load_err
);

  localparam longint WIDTH_LIM = (64'sd1 <<< WIDTH) - 64'sd1;
  localparam longint STEP_LIM  = (64'sd1 <<< STEP_W) - 64'sd1;

  if (WIDTH < 1 || WIDTH > 31 || STEP_W < 1 || STEP_W > 31 ||
      longint'(MAX_VALUE) > WIDTH_LIM || MAX_VALUE < 0 || RESET_VALUE < 0 ||
      RESET_VALUE > MAX_VALUE || STEP_LIM > longint'(MAX_VALUE) + 64'sd1) begin : g_param_check
    $fatal(1, "updown_counter: illegal WIDTH/MAX_VALUE/STEP_W/RESET_VALUE combination");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] out_q, out_d;
  logic             at_zero_q, at_max_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             load_err_q, load_err_d;
  logic             count_req;
  cnt_next_t        nc;
  logic             unused_hi;

  assign nc = next_count(CNT_W_MAX'(out_q), CNT_W_MAX'(step),
                         up ? DIR_UP : DIR_DOWN, MODE, CNT_W_MAX'(MAX_VALUE));
  assign unused_hi = ^nc.value[CNT_W_MAX-1:WIDTH];
  assign count_req = en && (up != down) && (step != '0);

  always_comb begin
    out_d      = out_q;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      out_d = RST_V;
    end else if (load) begin
      if (load_val > MAX_V) begin
        out_d      = MAX_V;
        load_err_d = 1'b1;
      end else begin
        out_d = load_val;
      end
    end else if (count_req) begin
      out_d = nc.value[WIDTH-1:0];
      ovf_d = up & nc.wrap;
      udf_d = down & nc.wrap;
    end
  end

  // Flags come from out_d so they line up with out in the same cycle.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      out_q      <= RST_V;
      at_zero_q  <= (RST_V == '0);
      at_max_q   <= (RST_V == MAX_V);
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      at_zero_q  <= (out_d == '0);
      at_max_q   <= (out_d == MAX_V);
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      load_err_q <= load_err_d;
    end
  end

  assign out      = out_q;
  assign at_zero  = at_zero_q;
  assign at_max   = at_max_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;
  assign load_err = load_err_q;

endmodule
